// File: rtl/ps2_edge_pkg.sv
// ps2_edge_pkg: shared Mode encodings, idle level and counter-width helper for the PS/2 line edge filter.
package ps2_edge_pkg;
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_RISE = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;
  localparam logic IDLE_LEVEL_DEF = 1'b1;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ps2_line_filter_chan.sv
// ps2_line_filter_chan: one line's synchroniser, tick-sampled debounce filter and registered edge pulses.
// PS2_GLITCH_COUNT_EN adds a saturating count of rejected glitches.
module ps2_line_filter_chan
  import ps2_edge_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter logic IDLE_LEVEL  = IDLE_LEVEL_DEF
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       pin_i,
  input  logic       tick_i,
`ifdef PS2_GLITCH_COUNT_EN
  input  logic       glitch_clr_i,
  output logic [7:0] glitch_cnt_o,
`endif
  output logic       level_o,
  output logic       h2l_o,
  output logic       l2h_o
);
  localparam int FW = cnt_w(FILT_LEN + 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, h2l_q, h2l_d, l2h_q, l2h_d;
  logic diff, accept;
  assign diff   = sync_q[SYNC_STAGES-1] != level_q;
  assign accept = tick_i && diff && (cnt_q == FW'(FILT_LEN - 1));
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d   = !tick_i ? cnt_q : (!diff || accept) ? '0 : cnt_q + FW'(1);
    level_d = accept ? ~level_q : level_q;
    h2l_d   = accept && level_q;
    l2h_d   = accept && !level_q;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_q   <= '0;
      level_q <= IDLE_LEVEL;
      h2l_q   <= 1'b0;
      l2h_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      h2l_q   <= h2l_d;
      l2h_q   <= l2h_d;
    end
  end
  assign level_o = level_q;
  assign h2l_o   = h2l_q;
  assign l2h_o   = l2h_q;
`ifdef PS2_GLITCH_COUNT_EN
  logic [7:0] gcnt_q, gcnt_d;
  // A glitch is a partial count abandoned because the line returned to the accepted level.
  always_comb begin
    gcnt_d = glitch_clr_i ? 8'd0 :
             (tick_i && !diff && cnt_q != '0 && gcnt_q != 8'hFF) ? gcnt_q + 8'd1 : gcnt_q;
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) gcnt_q <= 8'd0;
    else       gcnt_q <= gcnt_d;
  end
  assign glitch_cnt_o = gcnt_q;
`endif
endmodule

// File: rtl/ps2_line_edge_filter.sv
// ps2_line_edge_filter: CH-channel PS/2 line synchroniser/debouncer with shared prescaler and Mode-gated edge pulses.
// PS2_GLITCH_COUNT_EN adds Glitch_Clr/Glitch_Cnt.
module ps2_line_edge_filter
  import ps2_edge_pkg::*;
#(
  parameter int   CH          = 2,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter int   DIV         = 25,
  parameter logic IDLE_LEVEL  = IDLE_LEVEL_DEF
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [CH-1:0] Pin_In,
  input  logic [1:0]    Mode,
`ifdef PS2_GLITCH_COUNT_EN
  input  logic          Glitch_Clr,
  output logic [CH*8-1:0] Glitch_Cnt,
`endif
  output logic          Sample_Tick,
  output logic [CH-1:0] Level_Out,
  output logic [CH-1:0] H2L_Sig,
  output logic [CH-1:0] L2H_Sig,
  output logic [CH-1:0] Edge_Sig
);
  localparam int PW = cnt_w(DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, fall_en, rise_en;
  // The strobe is registered from the next count so it stays low while in reset.
  always_comb begin
    pre_d  = (pre_q == PW'(DIV - 1)) ? '0 : pre_q + PW'(1);
    tick_d = pre_d == PW'(DIV - 1);
  end
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end
  assign Sample_Tick = tick_q;
  assign fall_en  = (Mode == MODE_FALL) || (Mode == MODE_BOTH);
  assign rise_en  = (Mode == MODE_RISE) || (Mode == MODE_BOTH);
  assign Edge_Sig = (H2L_Sig & {CH{fall_en}}) | (L2H_Sig & {CH{rise_en}});
  for (genvar c = 0; c < CH; c++) begin : gen_ch
    ps2_line_filter_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_chan (
      .CLK         (CLK),
      .RSTn        (RSTn),
      .pin_i       (Pin_In[c]),
      .tick_i      (tick_q),
`ifdef PS2_GLITCH_COUNT_EN
      .glitch_clr_i(Glitch_Clr),
      .glitch_cnt_o(Glitch_Cnt[c*8 +: 8]),
`endif
      .level_o     (Level_Out[c]),
      .h2l_o       (H2L_Sig[c]),
      .l2h_o       (L2H_Sig[c])
    );
  end
endmodule

// File: tb/tb_ps2_line_edge_filter.sv
// tb_ps2_line_edge_filter: two configurations (DIV=1/FILT=3/SYNC=2 and DIV=4/FILT=2/SYNC=3) checked each cycle
// against a sample-history reference model; directed reset/latency/glitch/mode cases then random stimulus.
module tb_ps2_line_edge_filter;
  logic CLK = 1'b0, RSTn = 1'b0, glitch_clr = 1'b0;
  logic [1:0] pin = 2'b11, mode = 2'b00;
  logic tick_a, tick_b;
  logic [1:0] lv_a, h2l_a, l2h_a, ed_a, lv_b, h2l_b, l2h_b, ed_b;
`ifdef PS2_GLITCH_COUNT_EN
  logic [15:0] gc_a, gc_b;
`endif
  int checks = 0, errors = 0;
  int div_p[2]  = '{1, 4};
  int filt_p[2] = '{3, 2};
  int sync_p[2] = '{2, 3};
  logic [1:0] ph[$];
  logic [1:0] m_lvl[2], m_h2l[2], m_l2h[2];
  int m_run[2][2], m_g[2][2];
  int first_h2l = -1, ed_cnt = 0, sim_cnt = 0, tick_cnt = 0, k;

  always #5 CLK = ~CLK;

  ps2_line_edge_filter #(.CH(2), .SYNC_STAGES(2), .FILT_LEN(3), .DIV(1), .IDLE_LEVEL(1'b1)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .Pin_In(pin), .Mode(mode),
`ifdef PS2_GLITCH_COUNT_EN
    .Glitch_Clr(glitch_clr), .Glitch_Cnt(gc_a),
`endif
    .Sample_Tick(tick_a), .Level_Out(lv_a), .H2L_Sig(h2l_a), .L2H_Sig(l2h_a), .Edge_Sig(ed_a));

  ps2_line_edge_filter #(.CH(2), .SYNC_STAGES(3), .FILT_LEN(2), .DIV(4), .IDLE_LEVEL(1'b1)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .Pin_In(pin), .Mode(mode),
`ifdef PS2_GLITCH_COUNT_EN
    .Glitch_Clr(glitch_clr), .Glitch_Cnt(gc_b),
`endif
    .Sample_Tick(tick_b), .Level_Out(lv_b), .H2L_Sig(h2l_b), .L2H_Sig(l2h_b), .Edge_Sig(ed_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] gate(input logic [1:0] h, input logic [1:0] l);
    return (h & {2{mode[0]}}) | (l & {2{mode[1]}});
  endfunction

  function automatic logic tick_after(input int n, input int d);
    return n >= 1 && (n % d) == d - 1;
  endfunction

  task automatic model_reset();
    ph.delete();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 2'b11; m_h2l[i] = 2'b00; m_l2h[i] = 2'b00;
      for (int c = 0; c < 2; c++) begin m_run[i][c] = 0; m_g[i][c] = 0; end
    end
  endtask

  // Edge n sees the pin captured at edge n-SYNC and the tick raised after edge n-1.
  task automatic model_edge(input logic [1:0] p, input logic clr);
    int n = ph.size() + 1;
    for (int i = 0; i < 2; i++) begin
      logic [1:0] so;
      logic tk;
      so = (n - sync_p[i] >= 1) ? ph[n - sync_p[i] - 1] : 2'b11;
      tk = tick_after(n - 1, div_p[i]);
      m_h2l[i] = 2'b00; m_l2h[i] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (tk) begin
          if (so[c] == m_lvl[i][c]) begin
            if (m_run[i][c] != 0 && m_g[i][c] < 255) m_g[i][c]++;
            m_run[i][c] = 0;
          end else if (m_run[i][c] + 1 == filt_p[i]) begin
            m_lvl[i][c] = so[c];
            if (so[c]) m_l2h[i][c] = 1'b1; else m_h2l[i][c] = 1'b1;
            m_run[i][c] = 0;
          end else m_run[i][c]++;
        end
        if (clr) m_g[i][c] = 0;
      end
    end
    ph.push_back(p);
  endtask

  task automatic step(input logic [1:0] p);
    int n;
    pin = p;
    @(posedge CLK);
    model_edge(p, glitch_clr);
    #1;
    n = ph.size();
    check("tick_a", tick_a, tick_after(n, 1));
    check("tick_b", tick_b, tick_after(n, 4));
    check("lvl_a", lv_a, m_lvl[0]);
    check("lvl_b", lv_b, m_lvl[1]);
    check("h2l_a", h2l_a, m_h2l[0]);
    check("h2l_b", h2l_b, m_h2l[1]);
    check("l2h_a", l2h_a, m_l2h[0]);
    check("l2h_b", l2h_b, m_l2h[1]);
    check("edge_a", ed_a, gate(m_h2l[0], m_l2h[0]));
    check("edge_b", ed_b, gate(m_h2l[1], m_l2h[1]));
`ifdef PS2_GLITCH_COUNT_EN
    check("gcnt_a", gc_a, {8'(m_g[0][1]), 8'(m_g[0][0])});
    check("gcnt_b", gc_b, {8'(m_g[1][1]), 8'(m_g[1][0])});
`endif
    if (h2l_a != 2'b00 && first_h2l < 0) first_h2l = n;
    ed_cnt += $countones(ed_a);
    if (ed_a == 2'b11) sim_cnt++;
    if (tick_b) tick_cnt++;
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic [1:0] p);
    pin = p;
    #2 RSTn = 1'b0;
    #1 model_reset();
    check("rst_lvl_a", lv_a, 2'b11);
    check("rst_lvl_b", lv_b, 2'b11);
    check("rst_pulse_a", {h2l_a, l2h_a, ed_a}, 6'b0);
    check("rst_pulse_b", {h2l_b, l2h_b, ed_b}, 6'b0);
    check("rst_tick", {tick_a, tick_b}, 2'b00);
`ifdef PS2_GLITCH_COUNT_EN
    check("rst_gcnt", {gc_a, gc_b}, 32'd0);
`endif
    @(negedge CLK);
    RSTn = 1'b1;
    first_h2l = -1;
  endtask

  initial begin
    logic [1:0] rp;
    @(negedge CLK);
    do_reset(2'b11);
    repeat (8) step(2'b11);
    repeat (3) step(2'b00);
    do_reset(2'b00);
    repeat (12) step(2'b00);
    check("rst_release_lat", first_h2l, 5);
    check("rst_release_lvl", lv_a, 2'b00);
    repeat (12) step(2'b11);
    first_h2l = -1;
    k = ph.size() + 1;
    repeat (10) step(2'b10);
    check("fall_lat", first_h2l, k + 4);
    repeat (10) step(2'b11);
    glitch_clr = 1'b1; step(2'b11); glitch_clr = 1'b0;
    repeat (2) step(2'b10);
    repeat (8) step(2'b11);
    check("glitch_lvl", lv_a[0], 1'b1);
`ifdef PS2_GLITCH_COUNT_EN
    check("glitch_one", gc_a[7:0], 8'd1);
`endif
    repeat (300) begin
      repeat (2) step(2'b10);
      repeat (3) step(2'b11);
    end
`ifdef PS2_GLITCH_COUNT_EN
    check("glitch_sat", gc_a[7:0], 8'd255);
    glitch_clr = 1'b1; step(2'b11); glitch_clr = 1'b0;
    check("glitch_clr", gc_a[7:0], 8'd0);
`endif
    tick_cnt = 0;
    repeat (40) step(2'b11);
    check("tick_rate", tick_cnt, 10);
    mode = 2'b00; repeat (12) step(2'b10);
    mode = 2'b01; ed_cnt = 0;
    repeat (12) step(2'b11); repeat (12) step(2'b10);
    check("mode_fall", ed_cnt, 1);
    mode = 2'b11; ed_cnt = 0;
    repeat (12) step(2'b11); repeat (12) step(2'b10);
    check("mode_both", ed_cnt, 2);
    mode = 2'b00; ed_cnt = 0;
    repeat (12) step(2'b11); repeat (12) step(2'b10);
    check("mode_none", ed_cnt, 0);
    mode = 2'b11; repeat (12) step(2'b11);
    sim_cnt = 0;
    repeat (12) step(2'b00);
    check("simul_fall", sim_cnt, 1);
    repeat (12) step(2'b11);
    repeat (300) begin
      if ($urandom_range(0, 49) == 0) do_reset(2'($urandom));
      mode = 2'($urandom);
      glitch_clr = $urandom_range(0, 15) == 0;
      rp = 2'($urandom);
      repeat ($urandom_range(1, 12)) step(rp);
      glitch_clr = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_line_edge_filter.md
Name: ps2_line_edge_filter

Overview:
- Parametrised, multi-channel successor to the PS/2 clock falling-edge detector.
- Synchronises CH asynchronous PS/2 lines (clock and data, or several ports) into the CLK domain.
- Debounces each line with a prescaled sampling filter.
- Emits one-CLK falling, rising and mode-selected edge pulses per channel. Feeds the PS/2 receiver/transmitter FSMs in the ps2_uart path.

Parameters:
- CH, 2, number of independent input lines.
- SYNC_STAGES, 2, synchroniser flop depth; legal range 2..4.
- FILT_LEN, 3, consecutive differing sample ticks needed to accept a new level; 1 means no filtering.
- DIV, 25, CLK cycles per sample tick; 1 means sample every cycle.
- IDLE_LEVEL, 1'b1, reset value of the synchronisers and filtered levels (PS/2 idles high).

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Pin_In  in  CH  raw asynchronous line inputs.
- Mode  in  2  edge select for Edge_Sig: 00 none, 01 falling, 10 rising, 11 both.
- Sample_Tick  out  1  one-CLK prescaler strobe.
- Level_Out  out  CH  filtered line levels.
- H2L_Sig  out  CH  one-CLK falling-edge pulse per channel.
- L2H_Sig  out  CH  one-CLK rising-edge pulse per channel.
- Edge_Sig  out  CH  H2L_Sig/L2H_Sig gated by Mode.

Behaviour:
- Reset: RSTn is asynchronous, active-low; clock is CLK. All state clears on RSTn low, with no clock required. After reset:
  - Synchroniser flops and Level_Out = {CH{IDLE_LEVEL}}.
  - Filter counters = 0; prescaler = 0.
  - Sample_Tick, H2L_Sig, L2H_Sig = 0.
- Reset mid-operation aborts any partial filter count. No edge pulse is produced on reset release, even if Pin_In differs from IDLE_LEVEL; the change is then filtered normally.
- Prescaler: counter 0..DIV-1, wraps to 0. Sample_Tick = 1 for exactly the cycle in which counter == DIV-1. With DIV=1, Sample_Tick is constantly 1 after reset.
- Counter width is $clog2(DIV) (minimum 1). Filter counter width is $clog2(FILT_LEN+1).
- Filter, per channel, evaluated only on Sample_Tick; counters hold otherwise:
  - sync_out == Level_Out: counter <= 0.
  - sync_out != Level_Out and counter == FILT_LEN-1: Level_Out <= sync_out, counter <= 0, and the matching edge pulse is set.
  - Otherwise: counter <= counter+1.
- Edge pulses are registered and assert in the same cycle Level_Out changes, for exactly one CLK. The next cycle clears them. Falling 1->0 drives H2L_Sig; rising 0->1 drives L2H_Sig. The two cannot both be high on one channel.
- Edge_Sig is combinational from the registered pulses and Mode. A Mode change takes effect the same cycle.
- Latency with DIV=1: if Pin_In changes and is first captured at CLK edge k and stays stable, Level_Out and the pulse update at edge k+SYNC_STAGES+FILT_LEN-1.
- Latency with DIV>1: at most SYNC_STAGES+FILT_LEN*DIV cycles.
- A line reverting before FILT_LEN ticks produces no change and no pulse. Channels are fully independent; simultaneous edges on several channels all pulse in the same cycle.

Optional Feature:
- Macro: PS2_GLITCH_COUNT_EN.
- Defined: adds input Glitch_Clr (1) and output Glitch_Cnt (CH*8). Each channel keeps an 8-bit saturating count (sticks at 255) of rejected glitches. A rejected glitch is a Sample_Tick where the counter is nonzero and sync_out == Level_Out.
  - Glitch_Clr = 1 zeroes all counts on the next edge and has priority over an increment in that cycle.
  - Counts reset to 0 on RSTn.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ps2_edge_pkg holds:
  - Mode encodings: MODE_NONE=2'b00, MODE_FALL=2'b01, MODE_RISE=2'b10, MODE_BOTH=2'b11.
  - Default IDLE_LEVEL.
  - Counter-width helper.
- Sub-module ps2_line_filter_chan contains one channel's synchroniser, filter counter, level register, edge pulses and optional glitch counter. The top instantiates it CH times in a generate loop and owns the shared prescaler and Mode gating.

Test Plan:
- Reset (CH=2, DIV=1, SYNC=2, FILT=3): assert RSTn low mid-count with Pin_In=2'b00 -> Level_Out=2'b11, all pulses 0. Release -> H2L_Sig[1:0] pulse once each, 4 edges after first capture, Level_Out=2'b00; no pulse at release itself.
- Falling edge (DIV=1, SYNC=2, FILT=3): Pin_In[0] 1->0 captured at edge k -> H2L_Sig[0] high for exactly edge k+4 to k+5, Level_Out[0]=0 from k+4. Rising back -> L2H_Sig[0] single pulse.
- Glitch reject (FILT=3): Pin_In[0] low for 2 cycles then high -> no pulse, Level_Out[0] stays 1. With PS2_GLITCH_COUNT_EN: Glitch_Cnt[7:0]=1. After 300 glitches it reads 255. Glitch_Clr -> 0.
- Prescaler (DIV=4, FILT=2): Sample_Tick every 4th cycle. Stable low input -> edge within SYNC_STAGES+8 cycles, aligned to a tick cycle.
- Mode gating: Mode=01, a rise then a fall -> Edge_Sig only on the fall. Mode=11 -> both. Mode=00 -> none. Simultaneous falls on ch0/ch1 -> both pulse in the same cycle.
